universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
//
// PURPOSE
// - 4-bit universal shift register: hold, shift right, shift left, or parallel load.
// - Operation is selected each clock by a 2-bit mode code.
// - General-purpose datapath/storage element.
// - Single clock domain, asynchronous active-high clear.
//
// PARAMETERS
// - WIDTH  default 4  register width in bits.
//   Ports parin/out are WIDTH wide; the bench uses 4.
//
// PORTS
// - clk    input   1      clock; all state updates on rising edge
// - clr    input   1      reset: asynchronous, active-high; forces out to 0
// - parin  input   WIDTH  parallel load data
// - sel    input   2      mode select; declared [0:1], so sel[0] is the MSB of the code
// - out    output  WIDTH  register contents (registered, no combinational path from inputs)
//
// BEHAVIOUR
// - One clock (clk), rising-edge triggered.
// - Reset is asynchronous and active-high (clr).
//   - clr=1: out = 0 immediately, independent of clk.
//   - out holds 0 while clr stays high.
//   - clr has priority over every sel code.
// - Release: first rising edge with clr=0 performs the operation selected by sel.
// - Mode codes (numeric value of sel), evaluated at each rising edge with clr=0:
//   - 2'b00 hold:         out <= out
//   - 2'b01 shift right:  out <= {1'b0, out[W-1:1]}  (MSB zero-filled, LSB discarded)
//   - 2'b10 shift left:   out <= {out[W-2:0], 1'b0}  (LSB zero-filled, MSB discarded)
//   - 2'b11 parallel load: out <= parin
// - Latency: result visible one clock after the edge that samples sel/parin.
//   No other pipeline stages.
// - No rotation: after WIDTH consecutive shifts in the same direction, out = 0.
// - parin is ignored in all modes except 2'b11.
// - sel/parin changes between edges have no effect until the next rising edge.
// - Reset mid-operation: clr asserted at any time aborts the current mode.
//   out reads 0 regardless of sel.
// - X/Z on sel: treat as hold (out unchanged).
// - Without any clr assertion, out is undefined until the first parallel load.
//   Shifting an undefined value leaves it undefined.
//   Benches must clear or load before checking.
//
// TESTING
// - Clock period 40 ns (20 ns half-period); stimulus changes away from rising edges.
// - T1 reset:
//   - clr=1 mid-cycle -> out=4'b0000 before next edge.
//   - Hold clr=1 with sel=2'b11, parin=4'b1011 -> out stays 0000.
// - T2 load:
//   - clr=0, sel=2'b11, parin=4'b1011, one edge -> out=1011.
//   - Change parin to 0110 with sel=2'b00 -> out stays 1011.
// - T3 shift right:
//   - From 1011, sel=2'b01, 4 edges -> out = 0101, 0010, 0001, 0000.
// - T4 shift left:
//   - Load 1011, sel=2'b10, 4 edges -> out = 0110, 1100, 1000, 0000.
// - T5 mode mix:
//   - Load 1011, then sel=01 (out 0101), then sel=10 (out 1010), then sel=00 x2 -> out stays 1010.
// - T6 async clear mid-run:
//   - Shifting left from 1011, assert clr between edges -> out=0000 at once.
//   - Deassert clr with sel=2'b11, parin=4'b1011 -> next edge out=1011.

Source files
------------

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// selected per clock by a 2-bit mode code. Shifts are zero-filling and do not rotate.
module universal_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] parin,
  input  logic [0:1]       sel,
  output logic [WIDTH-1:0] out
);

  // Mode codes by numeric value of sel (sel[0] is the MSB of the code).
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [1:0]       mode;
  logic [WIDTH-1:0] next_val;

  assign mode = sel;

  // Next-value selection; anything that is not a recognised code (X/Z in simulation) holds.
  always_comb begin
    next_val = out;
    case (mode)
      MODE_HOLD: next_val = out;
      MODE_SHR:  next_val = {1'b0, out[WIDTH-1:1]};
      MODE_SHL:  next_val = {out[WIDTH-2:0], 1'b0};
      MODE_LOAD: next_val = parin;
      default:   next_val = out;
    endcase
  end

  // Register with asynchronous clear taking priority over every mode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out <= '0;
    end else begin
      out <= next_val;
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=4): directed vector table,
// hand-written async-clear sequences, and randomized traffic against an arithmetic model.
module tb_universal_shift_register;

  logic       clk;
  logic       clr;
  logic [3:0] parin;
  logic [0:1] sel;
  logic [3:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] parin;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[18];

  universal_shift_register #(.WIDTH(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .parin (parin),
    .sel   (sel),
    .out   (out)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the following rising edge.
  task automatic step(input logic c, input logic [1:0] s, input logic [3:0] p);
    @(negedge clk);
    clr   = c;
    sel   = s;
    parin = p;
    @(posedge clk);
    #1;
  endtask

  // Reference: shifts as divide/multiply by two modulo 16, load replaces the value.
  function automatic int ref_next(input int cur, input int code, input int pin);
    case (code)
      0:       return cur;
      1:       return cur / 2;
      2:       return (cur * 2) % 16;
      default: return pin;
    endcase
  endfunction

  initial begin
    int model;

    vecs[0]  = '{2'b11, 4'b1011, 4'b1011, "t2_load"};
    vecs[1]  = '{2'b00, 4'b0110, 4'b1011, "t2_hold"};
    vecs[2]  = '{2'b01, 4'b1111, 4'b0101, "t3_shr1"};
    vecs[3]  = '{2'b01, 4'b0000, 4'b0010, "t3_shr2"};
    vecs[4]  = '{2'b01, 4'b1010, 4'b0001, "t3_shr3"};
    vecs[5]  = '{2'b01, 4'b0101, 4'b0000, "t3_shr4"};
    vecs[6]  = '{2'b11, 4'b1011, 4'b1011, "t4_load"};
    vecs[7]  = '{2'b10, 4'b1111, 4'b0110, "t4_shl1"};
    vecs[8]  = '{2'b10, 4'b0001, 4'b1100, "t4_shl2"};
    vecs[9]  = '{2'b10, 4'b1001, 4'b1000, "t4_shl3"};
    vecs[10] = '{2'b10, 4'b0111, 4'b0000, "t4_shl4"};
    vecs[11] = '{2'b00, 4'b1111, 4'b0000, "t4_hold0"};
    vecs[12] = '{2'b11, 4'b1011, 4'b1011, "t5_load"};
    vecs[13] = '{2'b01, 4'b0000, 4'b0101, "t5_shr"};
    vecs[14] = '{2'b10, 4'b1111, 4'b1010, "t5_shl"};
    vecs[15] = '{2'b00, 4'b0001, 4'b1010, "t5_hold1"};
    vecs[16] = '{2'b00, 4'b0110, 4'b1010, "t5_hold2"};
    vecs[17] = '{2'b11, 4'b0110, 4'b0110, "load_0110"};

    clr   = 1'b0;
    sel   = 2'b00;
    parin = 4'b0000;

    // T1: clear asserted mid-cycle takes effect without a clock edge.
    @(posedge clk);
    #7;
    clr = 1'b1;
    #1;
    check("t1_async_clr", out, 4'b0000);
    sel   = 2'b11;
    parin = 4'b1011;
    @(posedge clk);
    #1;
    check("t1_clr_over_load", out, 4'b0000);
    @(posedge clk);
    #1;
    check("t1_clr_held", out, 4'b0000);

    for (int i = 0; i < 18; i++) begin
      step(1'b0, vecs[i].sel, vecs[i].parin);
      check(vecs[i].name, out, vecs[i].exp);
    end

    // T6: clear in the middle of a left-shift run, then reload on release.
    step(1'b0, 2'b11, 4'b1011);
    check("t6_load", out, 4'b1011);
    step(1'b0, 2'b10, 4'b0000);
    check("t6_shl1", out, 4'b0110);
    #9;
    clr = 1'b1;
    #1;
    check("t6_async_clr", out, 4'b0000);
    @(posedge clk);
    #1;
    check("t6_clr_over_shl", out, 4'b0000);
    step(1'b0, 2'b11, 4'b1011);
    check("t6_reload", out, 4'b1011);

    // Randomized traffic against the arithmetic model.
    model = 11;
    for (int i = 0; i < 400; i++) begin
      logic       r_clr;
      logic [1:0] r_sel;
      logic [3:0] r_par;
      r_clr = ($urandom_range(0, 15) == 0);
      r_sel = 2'($urandom_range(0, 3));
      r_par = 4'($urandom_range(0, 15));
      @(negedge clk);
      clr   = r_clr;
      sel   = r_sel;
      parin = r_par;
      if (r_clr) begin
        #1;
        model = 0;
        check("rand_async_clr", out, 4'(model));
      end
      @(posedge clk);
      #1;
      if (!r_clr) model = ref_next(model, int'(r_sel), int'(r_par));
      check("rand_step", out, 4'(model));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
